seg7_scan_driver: RTL

Time-multiplexed driver for the seven-digit, eight-segment LED display of the digital clock. It consumes the 56-bit segment image produced by the display formatter and lights one digit at a time at a fixed refresh rate. Each full seven-digit scan uses a single snapshot of the image, so no scan ever shows a mix of old and new values. It sits directly downstream of the display formatter and drives the board's anode and segment pins.

---
 rtl/seg7_scan_driver.sv | 98 +++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for a 7-digit, 8-segment active-low LED display.
// Optional inter-digit ghost blanking is compiled in with SEG7_SCAN_GHOST_BLANK_EN.
module seg7_scan_driver #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic [55:0] disp_reg,
  output logic [6:0]  an,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int               CNT_W      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM  = CNT_W'(BLANK_CYC);
  localparam logic [2:0]       DIGIT_LAST = 3'd6;

`ifdef SEG7_SCAN_GHOST_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [55:0]      frame_q, frame_d;
  logic [6:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             fs_q, fs_d;

  // Unreachable digit codes select a dark pattern rather than stale data.
  function automatic logic [7:0] byte_sel(input logic [55:0] img, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = img[7:0];
      3'd1:    b = img[15:8];
      3'd2:    b = img[23:16];
      3'd3:    b = img[31:24];
      3'd4:    b = img[39:32];
      3'd5:    b = img[47:40];
      3'd6:    b = img[55:48];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // Slot/digit sequencing; the image is only re-sampled at the frame wrap.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    frame_d = frame_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (digit_q == DIGIT_LAST) begin
        digit_d = 3'd0;
        frame_d = disp_reg;
      end else begin
        digit_d = digit_q + 3'd1;
      end
    end
  end

  // Output decode from current state, registered one cycle later.
  always_comb begin
    an_d  = ~(7'b1 << digit_q);
    seg_d = byte_sel(frame_q, digit_q);
    fs_d  = (digit_q == 3'd0) && (cnt_q == '0);
    if (BLANK_EN && (cnt_q < BLANK_LIM)) begin
      an_d  = 7'h7F;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      cnt_q   <= '0;
      digit_q <= 3'd0;
      frame_q <= disp_reg;
      an_q    <= 7'h7F;
      seg_q   <= 8'hFF;
      fs_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      frame_q <= frame_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fs_q    <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

endmodule
